// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - register map and field constants for the interrupt controller
package irq_pkg;
  localparam int ID_W = 5;

  localparam logic [2:0] IRQ_PENDING = 3'd0;
  localparam logic [2:0] IRQ_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_EDGE    = 3'd2;
  localparam logic [2:0] IRQ_CLAIM   = 3'd3;
  localparam logic [2:0] IRQ_CTRL    = 3'd4;

  localparam int CTRL_GIE    = 0;
  localparam int CLAIM_VALID = 31;
endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder over active sources
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] active_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scan downward so the lowest set index is the last assignment made.
  always_comb begin
    valid_o = |active_i;
    id_o    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - memory-mapped interrupt controller with edge/level capture and claim
module irq_controller
  import irq_pkg::*;
#(
  parameter int                 NUM_SRC     = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] EDGE_RESET  = '1
) (
  input  logic               clk,
  input  logic               resetq,
  input  logic               select,
  input  logic [3:0]         we,
  input  logic               rd,
  input  logic [2:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq_out
);

  logic [NUM_SRC-1:0] src_s, rise, active, lane_mask, w1c, claim_clr;
  logic [NUM_SRC-1:0] prev_q, pending_q, pending_d, enable_q, enable_d, edge_q, edge_d;
  logic               gie_q, gie_d, irq_q, irq_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               enc_valid, wr_en, rd_en, claim_rd;
  logic [ID_W-1:0]    enc_id;
  logic               unused_wdata;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign src_s = irq_src;
    end else begin : g_sync
      logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= irq_src;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign src_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign wr_en        = select && (we != 4'b0000);
  assign rd_en        = select && rd;
  assign claim_rd     = rd_en && (addr == IRQ_CLAIM);
  assign rise         = src_s & ~prev_q;
  assign active       = pending_q & enable_q;
  assign unused_wdata = ^wdata[31:NUM_SRC];

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .active_i (active),
    .valid_o  (enc_valid),
    .id_o     (enc_id)
  );

  always_comb begin
    lane_mask = '0;
    w1c       = '0;
    claim_clr = '0;
    enable_d  = enable_q;
    edge_d    = edge_q;
    gie_d     = gie_q;
    for (int i = 0; i < NUM_SRC; i++) lane_mask[i] = we[i/8];
    if (wr_en) begin
      case (addr)
        IRQ_PENDING: w1c      = wdata[NUM_SRC-1:0] & lane_mask;
        IRQ_ENABLE:  enable_d = (enable_q & ~lane_mask) | (wdata[NUM_SRC-1:0] & lane_mask);
        IRQ_EDGE:    edge_d   = (edge_q & ~lane_mask) | (wdata[NUM_SRC-1:0] & lane_mask);
        IRQ_CTRL:    if (we[0]) gie_d = wdata[CTRL_GIE];
        default: ;
      endcase
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_clr[i] = claim_rd && enc_valid && (enc_id == ID_W'(i));
    end
    // Edge bits: a fresh rising edge beats any clear; level bits mirror the line.
    pending_d = (edge_q & (rise | (pending_q & ~(w1c | claim_clr)))) | (~edge_q & src_s);
    irq_d     = gie_q & (|active);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (addr)
        IRQ_PENDING: rdata_d[NUM_SRC-1:0] = pending_q;
        IRQ_ENABLE:  rdata_d[NUM_SRC-1:0] = enable_q;
        IRQ_EDGE:    rdata_d[NUM_SRC-1:0] = edge_q;
        IRQ_CLAIM: begin
          rdata_d[CLAIM_VALID] = enc_valid;
          rdata_d[ID_W-1:0]    = enc_id;
        end
        IRQ_CTRL:    rdata_d[CTRL_GIE] = gie_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= EDGE_RESET;
      gie_q     <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      prev_q    <= src_s;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      gie_q     <= gie_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign irq_out = irq_q;

endmodule
